// File: rtl/mips_single_pkg.sv
// Shared types and encodings for the single-cycle MIPS-subset CPU.
package mips_single_pkg;
  typedef logic [31:0] word_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] F_SLL    = 6'd0;
  localparam logic [5:0] F_MFHI   = 6'd16;
  localparam logic [5:0] F_MFLO   = 6'd18;
  localparam logic [5:0] F_MULTU  = 6'd25;
  localparam logic [5:0] F_ADD    = 6'd32;
  localparam logic [5:0] F_SUB    = 6'd34;
  localparam logic [5:0] F_AND    = 6'd36;
  localparam logic [5:0] F_OR     = 6'd37;
  localparam logic [5:0] F_SLT    = 6'd42;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL} alu_op_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_HI, WB_LO} wb_sel_e;

  function automatic word_t sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction
endpackage

// File: rtl/mips_single_cycle_alu.sv
// Combinational ALU: add/sub/and/or/signed-slt/sll with a zero flag for branches.
import mips_single_pkg::*;

module mips_alu (
  input  alu_op_e    op,
  input  word_t      a,
  input  word_t      b,
  input  logic [4:0] shamt,
  output word_t      y,
  output logic       zero
);
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLL: y = b << shamt;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);
endmodule

// File: rtl/mips_single_cycle_mem.sv
// Word memory (async read, sync write, wrapping index) and 32x32 register file.
import mips_single_pkg::*;

module mips_mem #(
  parameter int WORDS = 128
) (
  input  logic  clk,
  input  logic  we,
  input  word_t addr,
  input  word_t wd,
  output word_t rd
);
  localparam int AW = $clog2(WORDS);

  word_t mem_array [WORDS];
  logic  unused_addr;

  // Byte offset and bits above the array depth are ignored, so addresses wrap.
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign rd = mem_array[addr[AW+1:2]];

  always_ff @(posedge clk) begin
    if (we) mem_array[addr[AW+1:2]] <= wd;
  end
endmodule

module mips_regfile (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] ra1,
  input  logic [4:0] ra2,
  input  logic [4:0] wa,
  input  word_t      wd,
  output word_t      rd1,
  output word_t      rd2
);
  word_t file_array [0:31];

  assign rd1 = (ra1 == 5'd0) ? '0 : file_array[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : file_array[ra2];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) file_array[wa] <= wd;
  end
endmodule

// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS-subset CPU top. Define MIPS_SINGLE_MULT_EN to build HI/LO with MULTU/MFHI/MFLO.
import mips_single_pkg::*;

module mips_single_cycle #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128
) (
  input logic clk,
  input logic rst
);
  word_t      pc_q, pc_d, pc, pc_plus4, br_tgt, imm_ext, instr;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt, rf_wa;
  word_t      rs_data, rt_data, alu_b, alu_y, dm_rd, rfile_wd, hi_q, lo_q;
  logic       alu_zero, alu_b_imm, rf_we_dec, rf_we, dm_we_dec, dm_we;
  logic       is_beq, is_bne, is_jump, taken;
  alu_op_e    alu_op;
  wb_sel_e    wb_sel;
`ifdef MIPS_SINGLE_MULT_EN
  logic        hilo_we;
  logic [63:0] prod;
  word_t       hi_d, lo_d;
`endif

  assign pc     = pc_q;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];

  mips_mem #(.WORDS(IMEM_WORDS)) InstrMem (
    .clk(clk), .we(1'b0), .addr(pc), .wd('0), .rd(instr)
  );

  always_comb begin
    rf_we_dec = 1'b0;
    rf_wa     = rt;
    alu_op    = ALU_ADD;
    alu_b_imm = 1'b0;
    wb_sel    = WB_ALU;
    dm_we_dec = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jump   = 1'b0;
`ifdef MIPS_SINGLE_MULT_EN
    hilo_we   = 1'b0;
`endif
    case (opcode)
      OP_RTYPE: begin
        rf_wa = rd;
        case (funct)
          F_ADD: begin rf_we_dec = 1'b1; alu_op = ALU_ADD; end
          F_SUB: begin rf_we_dec = 1'b1; alu_op = ALU_SUB; end
          F_AND: begin rf_we_dec = 1'b1; alu_op = ALU_AND; end
          F_OR:  begin rf_we_dec = 1'b1; alu_op = ALU_OR;  end
          F_SLT: begin rf_we_dec = 1'b1; alu_op = ALU_SLT; end
          // The all-zero word is the canonical NOP and must not write $0's alias.
          F_SLL: begin rf_we_dec = (instr != '0); alu_op = ALU_SLL; end
`ifdef MIPS_SINGLE_MULT_EN
          F_MULTU: hilo_we = 1'b1;
          F_MFHI:  begin rf_we_dec = 1'b1; wb_sel = WB_HI; end
          F_MFLO:  begin rf_we_dec = 1'b1; wb_sel = WB_LO; end
`endif
          default: ;
        endcase
      end
      OP_ADDIU: begin rf_we_dec = 1'b1; alu_b_imm = 1'b1; end
      OP_LW:    begin rf_we_dec = 1'b1; alu_b_imm = 1'b1; wb_sel = WB_MEM; end
      OP_SW:    begin dm_we_dec = 1'b1; alu_b_imm = 1'b1; end
      OP_BEQ:   begin is_beq = 1'b1; alu_op = ALU_SUB; end
      OP_BNE:   begin is_bne = 1'b1; alu_op = ALU_SUB; end
      OP_J:     is_jump = 1'b1;
      default: ;
    endcase
  end

  // Architectural writes are masked while reset is low so a mid-run reset edge commits nothing.
  assign rf_we = rf_we_dec & rst;
  assign dm_we = dm_we_dec & rst;

  mips_regfile RegFile (
    .clk(clk), .we(rf_we), .ra1(rs), .ra2(rt), .wa(rf_wa), .wd(rfile_wd),
    .rd1(rs_data), .rd2(rt_data)
  );

  assign imm_ext = sext16(instr[15:0]);
  assign alu_b   = alu_b_imm ? imm_ext : rt_data;

  mips_alu u_alu (
    .op(alu_op), .a(rs_data), .b(alu_b), .shamt(shamt), .y(alu_y), .zero(alu_zero)
  );

  mips_mem #(.WORDS(DMEM_WORDS)) DatMem (
    .clk(clk), .we(dm_we), .addr(alu_y), .wd(rt_data), .rd(dm_rd)
  );

`ifdef MIPS_SINGLE_MULT_EN
  assign prod = {32'd0, rs_data} * {32'd0, rt_data};

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_we) {hi_d, lo_d} = prod;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
`else
  assign hi_q = '0;
  assign lo_q = '0;
`endif

  always_comb begin
    rfile_wd = alu_y;
    case (wb_sel)
      WB_MEM:  rfile_wd = dm_rd;
      WB_HI:   rfile_wd = hi_q;
      WB_LO:   rfile_wd = lo_q;
      default: rfile_wd = alu_y;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign taken    = (is_beq & alu_zero) | (is_bne & ~alu_zero);

  always_comb begin
    pc_d = pc_plus4;
    if (is_jump)    pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (taken) pc_d = br_tgt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end
endmodule

// File: tb/tb_mips_single_cycle.sv
// Scoreboard bench: stimulus queues the expected pc trace and register writes; a negedge monitor checks them.
module tb_mips_single_cycle;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_single_cycle dut (.clk(clk), .rst(rst));

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] pc_exp[$];
  wr_t         wr_exp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input int fn);
    logic [4:0] a, b, c, s;
    logic [5:0] f;
    a = rs[4:0]; b = rt[4:0]; c = rd[4:0]; s = sh[4:0]; f = fn[5:0];
    return {6'd0, a, b, c, s, f};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    logic [5:0]  o;
    logic [4:0]  a, b;
    logic [15:0] m;
    o = op[5:0]; a = rs[4:0]; b = rt[4:0]; m = imm[15:0];
    return {o, a, b, m};
  endfunction

  function automatic logic [31:0] j_ins(input int tgt);
    logic [25:0] t;
    t = tgt[25:0];
    return {6'd2, t};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    dut.InstrMem.mem_array[addr >> 2] = w;
  endtask

  task automatic exp_wr(input int wa, input logic [31:0] wd);
    wr_t e;
    e.wa = wa[4:0];
    e.wd = wd;
    wr_exp.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pc_exp.size() != 0) chk("pc_trace", dut.pc, pc_exp.pop_front());
      if (dut.rf_we && dut.rf_wa != 5'd0) begin
        if (wr_exp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_wr: got $%0d<=%h expected no write", dut.rf_wa, dut.rfile_wd);
        end else begin
          wr_t e;
          e = wr_exp.pop_front();
          chk("wr_addr", {27'd0, dut.rf_wa}, {27'd0, e.wa});
          chk("wr_data", dut.rfile_wd, e.wd);
        end
      end
    end
  end

  initial begin
    int trace[30] = '{'h000, 'h004, 'h008, 'h00C, 'h010, 'h01C, 'h020, 'h024, 'h028, 'h02C,
                      'h030, 'h034, 'h038, 'h03C, 'h100, 'h104, 'h108, 'h10C, 'h110, 'h118,
                      'h11C, 'h120, 'h124, 'h128, 'h12C, 'h130, 'h134, 'h138, 'h13C, 'h13C};
    // Any stray fetch of a filler word writes $9 and is flagged by the monitor.
    for (int i = 0; i < 128; i++) dut.InstrMem.mem_array[i] = i_ins(9, 0, 9, 'h99);
    put('h000, i_ins(9, 0, 1, 5));
    put('h004, i_ins(9, 0, 2, 3));
    put('h008, i_ins(9, 0, 7, 7));
    put('h00C, i_ins(9, 0, 8, 8));
    put('h010, i_ins(4, 1, 1, 2));
    put('h01C, i_ins(5, 1, 1, 5));
    put('h020, r_ins(1, 2, 3, 0, 32));
    put('h024, r_ins(1, 2, 3, 0, 34));
    put('h028, r_ins(1, 2, 3, 0, 36));
    put('h02C, r_ins(1, 2, 3, 0, 37));
    put('h030, r_ins(1, 2, 3, 0, 42));
    put('h034, i_ins(9, 0, 4, -4));
    put('h038, r_ins(0, 1, 5, 4, 0));
    put('h03C, j_ins('h40));
    put('h100, i_ins(9, 0, 0, 5));
    put('h104, r_ins(0, 1, 9, 0, 32));
    put('h108, i_ins(43, 0, 1, 8));
    put('h10C, i_ins(35, 0, 6, 8));
    put('h110, i_ins(4, 6, 1, 1));
    put('h118, i_ins(9, 0, 10, -1));
    put('h11C, r_ins(10, 1, 3, 0, 42));
    put('h120, i_ins(9, 0, 1, -1));
    put('h124, i_ins(9, 0, 2, 2));
    put('h128, r_ins(1, 2, 0, 0, 25));
    put('h12C, r_ins(0, 0, 7, 0, 16));
    put('h130, r_ins(0, 0, 8, 0, 18));
    put('h134, 32'h0000_0000);
    put('h138, 32'hFC00_0000);
    put('h13C, i_ins(4, 0, 0, -1));

    foreach (trace[i]) pc_exp.push_back(trace[i]);
    exp_wr(1, 5);  exp_wr(2, 3);  exp_wr(7, 7);  exp_wr(8, 8);
    exp_wr(3, 8);  exp_wr(3, 2);  exp_wr(3, 1);  exp_wr(3, 7);  exp_wr(3, 0);
    exp_wr(4, 32'hFFFF_FFFC);     exp_wr(5, 80);
    exp_wr(9, 5);  exp_wr(6, 5);  exp_wr(10, 32'hFFFF_FFFF);    exp_wr(3, 1);
    exp_wr(1, 32'hFFFF_FFFF);     exp_wr(2, 2);
`ifdef MIPS_SINGLE_MULT_EN
    exp_wr(7, 1);  exp_wr(8, 32'hFFFF_FFFE);
`endif

    repeat (2) @(posedge clk);
    #1 chk("reset_pc", dut.pc, 32'h0);
    rst    = 1'b1;
    mon_en = 1'b1;

    for (int k = 0; k < 200 && pc_exp.size() != 0; k++) @(posedge clk);
    #1 mon_en = 1'b0;
    chk("trace_remaining", pc_exp.size(), 0);
    chk("writes_remaining", wr_exp.size(), 0);

    chk("dmem_word2", dut.DatMem.mem_array[2], 32'd5);
    chk("reg_r3_slt_neg", dut.RegFile.file_array[3], 32'd1);
    chk("reg_r4_addiu", dut.RegFile.file_array[4], 32'hFFFF_FFFC);
    chk("reg_r5_sll", dut.RegFile.file_array[5], 32'd80);
    chk("reg_r6_lw", dut.RegFile.file_array[6], 32'd5);
    chk("reg_r9_r0_read", dut.RegFile.file_array[9], 32'd5);
`ifdef MIPS_SINGLE_MULT_EN
    chk("reg_r7_mfhi", dut.RegFile.file_array[7], 32'd1);
    chk("reg_r8_mflo", dut.RegFile.file_array[8], 32'hFFFF_FFFE);
`else
    chk("reg_r7_kept", dut.RegFile.file_array[7], 32'd7);
    chk("reg_r8_kept", dut.RegFile.file_array[8], 32'd8);
`endif
    chk("pc_halt", dut.pc, 32'h13C);

    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrun_reset_pc", dut.pc, 32'h0);
    @(posedge clk);
    #1 chk("midrun_wr_suppressed", dut.RegFile.file_array[1], 32'hFFFF_FFFF);
    chk("midrun_pc_held", dut.pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
